// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for the SPI core: TX FIFO -> one core transfer per byte,
// baud-derived wait, received byte -> RX FIFO. Mode-fault interrupt aborts the stream.
module spi_byte_sequencer #(
  parameter int DEPTH = 8,
  parameter int GUARD = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic [31:0] i_cfg,
  input  logic        i_cfg_load,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_data,
  output logic        o_tx_full,
  input  logic        i_rd_en,
  output logic [7:0]  o_rd_data,
  output logic        o_rx_empty,
  output logic        o_busy,
  input  logic        i_err_clr,
  output logic        o_tx_ovf,
  output logic        o_rx_ovf,
  output logic        o_modf,
  output logic [31:0] o_data_config,
  output logic [7:0]  o_spi_data,
  output logic        o_trans_en,
  input  logic [7:0]  i_spi_data,
  input  logic        i_spi_irq,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic        cfg_valid;
  logic [14:0] cnt, period, wait_load;

  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd, tx_wr_nxt;
  logic        tx_empty, rx_full;
  logic        tx_pop, tx_push, rx_pop, rx_push;
  logic        rx_capture, load_cnt, abort;
  logic        tx_ovf_evt, rx_ovf_evt;

  assign tx_empty   = (tx_wr == tx_rd);
  assign o_tx_full  = ((tx_wr ^ tx_rd) == FULL_DIFF);
  assign o_rx_empty = (rx_wr == rx_rd);
  assign rx_full    = ((rx_wr ^ rx_rd) == FULL_DIFF);
  assign o_rd_data  = rx_mem[rx_rd[AW-1:0]];

  // Popping frees a slot in the same cycle, so a push to a full FIFO survives a pop.
  assign tx_push    = i_wr_en && (!o_tx_full || tx_pop);
  assign tx_ovf_evt = i_wr_en && o_tx_full && !tx_pop;
  assign rx_pop     = i_rd_en && !o_rx_empty;
  assign rx_push    = rx_capture && (!rx_full || rx_pop);
  assign rx_ovf_evt = rx_capture && rx_full && !rx_pop;
  assign tx_wr_nxt  = tx_push ? tx_wr + PTR_ONE : tx_wr;

  // P = 16*(BR[6:4]+1) << BR[2:0]; the counter runs W-1 down to 0.
  assign period    = (15'(o_data_config[6:4]) + 15'd1) << (4'd4 + {1'b0, o_data_config[2:0]});
  assign wait_load = period + 15'(GUARD) - 15'd1;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cfg_valid && !tx_empty) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_spi_irq)      state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = tx_empty ? S_IDLE : S_LAUNCH;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop     = 1'b0;
    rx_capture = 1'b0;
    load_cnt   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE:    tx_pop = cfg_valid && !tx_empty;
      S_LAUNCH:  load_cnt = 1'b1;
      S_WAIT:    abort = i_spi_irq;
      S_CAPTURE: begin
        rx_capture = 1'b1;
        tx_pop     = !tx_empty;
      end
      default: ;
    endcase
    o_trans_en  = (state == S_LAUNCH);
    o_busy      = (state != S_IDLE);
    o_dbg_state = state;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      cnt           <= '0;
      o_spi_data    <= '0;
      o_data_config <= '0;
      cfg_valid     <= 1'b0;
    end else begin
      if (load_cnt)                         cnt <= wait_load;
      else if (state == S_WAIT && cnt != '0) cnt <= cnt - 15'd1;
      if (tx_pop) o_spi_data <= tx_mem[tx_rd[AW-1:0]];
      if (i_cfg_load && state == S_IDLE) begin
        o_data_config <= i_cfg;
        cfg_valid     <= 1'b1;
      end
    end
  end

  // A mode-fault flush discards everything, including a push landing in the same cycle.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      tx_wr <= tx_wr_nxt;
      if (abort)       tx_rd <= tx_wr_nxt;
      else if (tx_pop) tx_rd <= tx_rd + PTR_ONE;
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= i_wr_data;
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= i_spi_data;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_tx_ovf <= 1'b0;
      o_rx_ovf <= 1'b0;
      o_modf   <= 1'b0;
    end else begin
      o_tx_ovf <= (o_tx_ovf && !i_err_clr) || tx_ovf_evt;
      o_rx_ovf <= (o_rx_ovf && !i_err_clr) || rx_ovf_evt;
      o_modf   <= (o_modf && !i_err_clr) || abort;
    end
  end

endmodule

// File: doc/spi_byte_sequencer.md
# spi_byte_sequencer

Byte-stream front end that sits directly upstream of the SPI core and feeds its `i_data_config`, `i_data` and `i_trans_en` inputs. The host pushes bytes into a TX FIFO; the block launches one SPI byte transfer per entry and waits a baud-derived number of cycles. It then captures the core's received byte into an RX FIFO for the host to read. It also watches the core's interrupt and aborts the stream on a mode fault.

## Interface
- `DEPTH`, 8: entries per FIFO (TX and RX); power of two, 2..64.
- `GUARD`, 4: extra `i_sys_clk` cycles added to each byte wait, allowing for core SS/shift-register settling.
- `i_sys_clk` in 1: system clock, shared with the SPI core.
- `i_sys_rst` in 1: reset, asynchronous, active-high.
- `i_cfg` in 32: SPI configuration word, in core layout: [31:24] CR1, [23:16] CR2, [15:8] SR, [7:0] BR.
- `i_cfg_load` in 1: one-cycle strobe; latches `i_cfg`.
- `i_wr_en` in 1: TX FIFO push.
- `i_wr_data` in 8: TX byte.
- `o_tx_full` out 1: TX FIFO full.
- `i_rd_en` in 1: RX FIFO pop.
- `o_rd_data` out 8: RX FIFO head, first-word fall-through.
- `o_rx_empty` out 1: RX FIFO empty.
- `o_busy` out 1: FSM not in IDLE.
- `i_err_clr` in 1: clears all sticky error flags.
- `o_tx_ovf`, `o_rx_ovf`, `o_modf` out 1 each: sticky error flags.
- `o_data_config` out 32: drives core `i_data_config`.
- `o_spi_data` out 8: drives core `i_data`.
- `o_trans_en` out 1: drives core `i_trans_en`.
- `i_spi_data` in 8: from core `o_data`.
- `i_spi_irq` in 1: from core `o_interrupt`.

## Operation
- **Config register.**
  - `i_cfg_load` in IDLE latches `i_cfg` into `o_data_config` and sets the internal `cfg_valid` flag.
  - `i_cfg_load` while busy is ignored; no flag is set.
- **Byte period.** `P = 16 * (BR[6:4]+1) << BR[2:0]`, computed from the latched BR.
  - Range is 16..16384, held in a 15-bit counter.
  - The wait length is `W = P + GUARD`.
- **FSM states.**
  - IDLE:
    - If `cfg_valid` and the TX FIFO is non-empty: pop the TX head into `o_spi_data`, then go to LAUNCH.
  - LAUNCH (1 cycle):
    - Drive `o_trans_en=1`, load the counter with `W-1`, then go to WAIT.
  - WAIT:
    - Decrement the counter each cycle.
    - At 0, go to CAPTURE.
    - If `i_spi_irq` is sampled 1 in any WAIT cycle: set `o_modf`, flush the TX FIFO, go to IDLE, and do not capture.
  - CAPTURE (1 cycle):
    - Push `i_spi_data` into the RX FIFO. If the RX FIFO is full, drop the byte and set `o_rx_ovf`.
    - Then, if the TX FIFO is non-empty: pop into `o_spi_data` and go to LAUNCH. Otherwise go to IDLE.
- **Outputs.**
  - `o_trans_en` is 0 in every state except LAUNCH. This guarantees a rising edge per byte.
  - `o_spi_data` is stable from LAUNCH through CAPTURE.
- **FIFOs.**
  - Pointers are `log2(DEPTH)+1` bits with wrap bit; full when the pointers differ only in the MSB.
  - A push to a full TX FIFO is dropped and sets `o_tx_ovf`.
  - A pop from an empty RX FIFO is ignored; `o_rd_data` is then don't-care.
  - Simultaneous push and pop on the same FIFO are both honoured, including when full (pop frees the slot first) and when empty (the push is taken, the pop is ignored).
- **Error flags.**
  - `i_err_clr` clears all sticky flags.
  - If `i_err_clr` coincides with a new error event in the same cycle, the flag stays 1.
- **Reset.** Asynchronous; takes effect mid-transfer.
  - FIFOs empty; FSM to IDLE; `cfg_valid` = 0.
  - `o_data_config` = 0, `o_spi_data` = 0, `o_trans_en` = 0, `o_busy` = 0.
  - `o_tx_full` = 0, `o_rx_empty` = 1.
  - All error flags = 0.

## Timing
- FIFO write latency: a push in cycle n makes the entry visible in cycle n+1.
- **First transfer.**
  - Push in cycle 0, with config already loaded and FSM in IDLE.
  - Pop in cycle 1; `o_trans_en` high in cycle 2 (LAUNCH).
  - WAIT occupies cycles 3..2+W; CAPTURE in cycle 3+W.
  - `o_rx_empty` falls in cycle 4+W.
- **Back-to-back.** Successive `o_trans_en` pulses are exactly `W+2` cycles apart.
- **Busy flag.** `o_busy` is registered from the state: high from LAUNCH through CAPTURE, including across back-to-back bytes.
- **IRQ response.** `i_spi_irq` sampled in WAIT cycle k gives `o_modf=1` and IDLE in cycle k+1; TX empty from k+1.

## Test plan
- **Basic byte.** Load cfg BR=0x00 (P=16, W=20); push 0xA5; core returns 0x3C.
  - Expect `o_trans_en` pulse in cycle 2 and CAPTURE in cycle 23.
  - Expect `o_rd_data`=0x3C with `o_rx_empty`=0 in cycle 24.
- **Back-to-back and baud.** BR=0x12 (P=128, W=132); push 3 bytes back-to-back.
  - Expect exactly 3 `o_trans_en` pulses, 134 cycles apart.
  - Expect RX order preserved; `o_busy` continuously high.
- **TX overflow.** With no cfg loaded, push DEPTH+1 bytes.
  - Expect `o_tx_full`=1 after DEPTH pushes and `o_tx_ovf`=1.
  - Expect no `o_trans_en`.
  - Load cfg: expect exactly DEPTH transfers.
- **RX overflow.** Run DEPTH+2 transfers without reading.
  - Expect `o_rx_ovf`=1 and the first DEPTH bytes retained.
  - Apply `i_err_clr`: expect the flag cleared.
- **Mode fault abort.** Assert `i_spi_irq` mid-WAIT with 2 bytes queued.
  - Expect `o_modf`=1, FSM IDLE next cycle, TX empty, no RX push.
- **Reset mid-WAIT.** Assert `i_sys_rst` asynchronously between clock edges.
  - Expect all outputs at their reset values immediately, `o_trans_en`=0.
  - After release, expect no launch until a new `i_cfg_load`.
